// File: rtl/btb_port_sched.sv
// Shared BTB port scheduler; optional starvation guard under `BTB_SCHED_STARVE_EN`.

// Generic FIFO: show-ahead head, registered count, async active-low clear.
// Latency: a pushed entry becomes visible at the head one cycle after the push.
// Backpressure: the caller gates push on count < DEPTH and pop on count != 0.
module btb_sched_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;

   assign rdata = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end
endmodule

// Arbitrates the single BTB port between fetch lookups and queued updates.
// Latency: prediction registered 1 cycle after lookup; queued update written >= 1 cycle after push.
// Backpressure: fetch_ready drops on write cycles (DRAIN, idle-slot writes, forced writes); upd_ready drops when full.
module btb_port_sched #(
   parameter int ADDR_WIDTH   = 24,
   parameter int QUEUE_DEPTH  = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          fetch_valid,
   input  logic [ADDR_WIDTH-1:0]         fetch_pc,
   output logic                          fetch_ready,
   output logic                          pred_valid,
   output logic                          pred_hit,
   output logic [ADDR_WIDTH-1:0]         pred_target,
   input  logic                          upd_valid,
   input  logic [ADDR_WIDTH-1:0]         upd_pc,
   input  logic [ADDR_WIDTH-1:0]         upd_target,
   output logic                          upd_ready,
   output logic [ADDR_WIDTH-1:0]         btb_pc,
   output logic                          btb_branch_taken,
   output logic [ADDR_WIDTH-1:0]         btb_branch_target,
   input  logic                          btb_hit,
   input  logic [ADDR_WIDTH-1:0]         btb_target_out,
   output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_C = CW'(QUEUE_DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [ADDR_WIDTH-1:0] target;
   } upd_t;

   typedef enum logic {RUN, DRAIN} state_t;

   state_t          state, state_nxt;
   upd_t            head, wr_ent;
   logic            lookup, wr, push, forced_wr;
   logic [CW-1:0]   cnt_nxt;

   assign wr_ent = '{pc: upd_pc, target: upd_target};

   btb_sched_fifo #(.WIDTH($bits(upd_t)), .DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (wr),
      .wdata (wr_ent),
      .rdata (head),
      .count (queue_count)
   );

`ifdef BTB_SCHED_STARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;

   assign forced_wr = (state == RUN) && (starve_cnt == SW'(STARVE_LIMIT)) && (queue_count != '0);

   // Counts lookups granted while an update waits; any write restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         starve_cnt <= '0;
      else if (wr)
         starve_cnt <= '0;
      else if (state == RUN && queue_count != '0 && lookup)
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   assign forced_wr = 1'b0;
`endif

   // Everything facing the port is held quiet while reset is asserted.
   always_comb begin
      lookup            = 1'b0;
      wr                = 1'b0;
      fetch_ready       = 1'b0;
      upd_ready         = 1'b0;
      btb_pc            = '0;
      btb_branch_taken  = 1'b0;
      btb_branch_target = '0;
      if (reset) begin
         upd_ready = (queue_count < FULL_C);
         if (state == DRAIN || forced_wr)
            wr = 1'b1;
         else if (fetch_valid)
            lookup = 1'b1;
         else if (queue_count != '0)
            wr = 1'b1;

         if (wr) begin
            btb_pc            = head.pc;
            btb_branch_target = head.target;
            btb_branch_taken  = 1'b1;
         end else begin
            fetch_ready = 1'b1;
            if (lookup) btb_pc = fetch_pc;
         end
      end
   end

   assign push    = upd_valid & upd_ready;
   assign cnt_nxt = queue_count + CW'(push) - CW'(wr);

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (cnt_nxt == FULL_C) state_nxt = DRAIN;
         DRAIN:   if (cnt_nxt == '0)     state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         pred_valid  <= 1'b0;
         pred_hit    <= 1'b0;
         pred_target <= '0;
      end else begin
         state       <= state_nxt;
         pred_valid  <= fetch_valid & fetch_ready;
         pred_hit    <= lookup & btb_hit;
         pred_target <= (lookup & btb_hit) ? btb_target_out : '0;
      end
   end
endmodule
